// File: rtl/class_pkg.sv
// Shared constants, FSM states and counter type for the decision-tree frame loader.
package class_pkg;

  localparam int N_FEAT = 51;
  localparam int IN_W   = 8;
  localparam int BEATS  = (N_FEAT + IN_W - 1) / IN_W;
  localparam int BEAT_W = $clog2(BEATS) + 1;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    EVAL,
    HOLD
  } state_t;

  typedef logic [15:0] cnt_t;

endpackage

// File: rtl/class_frame_loader.sv
// Assembles a byte-stream feature frame into the tree's feature vector and returns
// the tree's class bit, one settle cycle later, on a valid/ready result port.
module class_frame_loader
  import class_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_last,
  output logic [N_FEAT-1:0] feat_o,
  input  logic              cls_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_class,
  output logic              err_o,
  output cnt_t              ok_cnt,
  output cnt_t              err_cnt
);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [N_FEAT-1:0]   feat_q, feat_d;
  logic                s_ready_q, s_ready_d;
  logic                m_valid_q, m_valid_d;
  logic                m_class_q, m_class_d;
  logic                err_q, err_d;
  cnt_t                ok_cnt_q, ok_cnt_d;
  cnt_t                err_cnt_q, err_cnt_d;
  logic                beat_acc;
  logic                last_slot;

  assign beat_acc  = s_valid && s_ready_q;
  assign last_slot = (beat_cnt_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    feat_d     = feat_q;
    m_valid_d  = m_valid_q;
    m_class_d  = m_class_q;
    err_d      = 1'b0;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          // Lane k of the vector takes the beat slot k / IN_W; bits past N_FEAT fall away.
          for (int i = 0; i < N_FEAT; i++) begin
            if (int'(beat_cnt_q) == i / IN_W) begin
              feat_d[i] = s_data[i % IN_W];
            end
          end
          if (last_slot) begin
            beat_cnt_d = '0;
            if (s_last) begin
              state_d = EVAL;
            end else begin
              state_d   = DRAIN;
              err_d     = 1'b1;
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end else if (s_last) begin
            beat_cnt_d = '0;
            err_d      = 1'b1;
            err_cnt_d  = err_cnt_q + 16'd1;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      DRAIN: begin
        if (beat_acc && s_last) begin
          state_d    = COLLECT;
          beat_cnt_d = '0;
        end
      end

      EVAL: begin
        m_class_d = cls_i;
        m_valid_d = 1'b1;
        ok_cnt_d  = ok_cnt_q + 16'd1;
        state_d   = HOLD;
      end

      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase

    // Registered from the next state so s_ready never depends on m_ready combinationally.
    s_ready_d = (state_d == COLLECT) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      beat_cnt_q <= '0;
      feat_q     <= '0;
      s_ready_q  <= 1'b1;
      m_valid_q  <= 1'b0;
      m_class_q  <= 1'b0;
      err_q      <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      feat_q     <= feat_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_class_q  <= m_class_d;
      err_q      <= err_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_ready = s_ready_q;
  assign feat_o  = feat_q;
  assign m_valid = m_valid_q;
  assign m_class = m_class_q;
  assign err_o   = err_q;
  assign ok_cnt  = ok_cnt_q;
  assign err_cnt = err_cnt_q;

endmodule
